cacheline_adaptor: RTL

CACHELINE_ADAPTOR -- requirements
Module: cacheline_adaptor

---
 rtl/cacheline_adaptor.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/cacheline_adaptor.sv
// Purpose: bridges a 256-bit cache line port to a 4 x 64-bit memory burst port.
// Latency: request sampled in IDLE, 4 beats on resp_i, then a one-cycle resp_o pulse.
// Backpressure: resp_i low stalls the burst indefinitely; request inputs are held until resp_o.
module cacheline_adaptor (
  input  logic         clk,
  input  logic         rst,

  // cache side
  input  logic [255:0] line_i,
  output logic [255:0] line_o,
  input  logic [31:0]  address_i,
  input  logic         read_i,
  input  logic         write_i,
  output logic         resp_o,

  // memory side
  input  logic [63:0]  burst_i,
  output logic [63:0]  burst_o,
  output logic [31:0]  address_o,
  output logic         read_o,
  output logic         write_o,
  input  logic         resp_i
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t       state;
  state_t       state_next;
  logic [1:0]   cnt;
  logic [1:0]   cnt_next;

  // Writeback line captured when a write is accepted, so the cache may
  // change line_i while the burst is in flight.
  logic [255:0] wbuf;

  // Pulses from the FSM telling the datapath what to capture this edge.
  logic         accept_read;
  logic         accept_write;
  logic         read_beat;

  // Bit offset of the current beat inside the 256-bit line.
  logic [7:0]   beat_lsb;

  assign beat_lsb = {cnt, 6'd0};

  // FSM state and beat counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 2'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state, counter and handshake outputs; write has priority over read.
  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    read_o       = 1'b0;
    write_o      = 1'b0;
    resp_o       = 1'b0;
    accept_read  = 1'b0;
    accept_write = 1'b0;
    read_beat    = 1'b0;

    case (state)
      IDLE: begin
        // resp_i is deliberately ignored here: stray strobes must not move cnt.
        if (write_i) begin
          state_next   = WRITE;
          cnt_next     = 2'd0;
          accept_write = 1'b1;
        end else if (read_i) begin
          state_next  = READ;
          cnt_next    = 2'd0;
          accept_read = 1'b1;
        end
      end

      READ: begin
        read_o = 1'b1;
        if (resp_i) begin
          read_beat = 1'b1;
          // cnt wraps 3 -> 0 on the last beat, leaving it clean for the next burst.
          cnt_next  = cnt + 2'd1;
          if (cnt == 2'd3) begin
            state_next = DONE;
          end
        end
      end

      WRITE: begin
        write_o = 1'b1;
        if (resp_i) begin
          cnt_next = cnt + 2'd1;
          if (cnt == 2'd3) begin
            state_next = DONE;
          end
        end
      end

      DONE: begin
        resp_o     = 1'b1;
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
        cnt_next   = 2'd0;
      end
    endcase
  end

  // Outgoing write beat is selected straight from cnt and is zero outside WRITE.
  always_comb begin
    burst_o = 64'd0;
    if (state == WRITE) begin
      burst_o = wbuf[beat_lsb +: 64];
    end
  end

  // Datapath captures: aligned address, writeback buffer and assembled read line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      address_o <= 32'd0;
      wbuf      <= 256'd0;
      line_o    <= 256'd0;
    end else begin
      if (accept_read || accept_write) begin
        // Line-align by clearing the 5 offset bits of a 32-byte line.
        address_o <= address_i & 32'hFFFF_FFE0;
      end
      if (accept_write) begin
        wbuf <= line_i;
      end
      if (read_beat) begin
        line_o[beat_lsb +: 64] <= burst_i;
      end
    end
  end

endmodule
